// File: rtl/udma_spim_clkgen_v2.sv
// SPI master clock generator: DIV_W-bit half-period divider, programmable CPOL,
// runt-free reconfiguration sequencer and lead/trail edge strobes in clk_i domain.
module udma_spim_clkgen_v2 #(
  parameter int DIV_W      = 8,
  parameter int DIV_RST    = 1,
  parameter int SETTLE_CYC = 2
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             clock_enable_i,
  input  logic [DIV_W-1:0] cfg_div_i,
  input  logic             cfg_cpol_i,
  input  logic             cfg_req_i,
  output logic             cfg_ack_o,
  output logic             spi_clk_o,
  output logic             spi_lead_o,
  output logic             spi_trail_o,
  output logic             busy_o
);

  localparam int              SW    = $clog2(SETTLE_CYC + 1);
  localparam logic [SW-1:0]   SLAST = SW'(SETTLE_CYC - 1);
  localparam logic [DIV_W-1:0] DRST = DIV_W'(DIV_RST);

  typedef enum logic [1:0] {PARK, RUN, LOAD, SETTLE} state_e;

  state_e           r_state, w_state_nxt;
  logic [1:0]       r_sync;
  logic [DIV_W-1:0] r_shd_div, r_div, r_cnt, w_cnt_nxt;
  logic             r_shd_cpol, r_cpol, r_pend;
  logic [SW-1:0]    r_scnt, w_scnt_nxt;
  logic             r_clk, r_lead, r_trail, r_busy;
  logic             w_clk_nxt, w_lead_nxt, w_trail_nxt;
  logic             w_cap, w_pend, w_tc, w_active;

  assign w_cap    = r_sync[0] & ~r_sync[1];
  // A capture landing on the same edge as a terminal count still counts in RUN.
  assign w_pend   = r_pend | w_cap;
  assign w_tc     = (r_cnt == r_div);
  assign w_active = (r_clk != r_cpol);

  assign cfg_ack_o   = r_sync[1];
  assign spi_clk_o   = r_clk;
  assign spi_lead_o  = r_lead;
  assign spi_trail_o = r_trail;
  assign busy_o      = r_busy;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_sync     <= '0;
      r_shd_div  <= DRST;
      r_shd_cpol <= 1'b0;
      r_pend     <= 1'b0;
      r_div      <= DRST;
      r_cpol     <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], cfg_req_i};
      if (w_cap) begin
        r_shd_div  <= cfg_div_i;
        r_shd_cpol <= cfg_cpol_i;
      end
      if (w_cap)                r_pend <= 1'b1;
      else if (r_state == LOAD) r_pend <= 1'b0;
      if (r_state == LOAD) begin
        r_div  <= r_shd_div;
        r_cpol <= r_shd_cpol;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_state <= PARK;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      PARK:   if (r_pend) w_state_nxt = LOAD;
              else if (clock_enable_i) w_state_nxt = RUN;
      RUN:    if (w_tc && w_active && (!clock_enable_i || w_pend)) w_state_nxt = PARK;
      LOAD:   w_state_nxt = SETTLE;
      SETTLE: if (r_scnt == SLAST) w_state_nxt = PARK;
      default: w_state_nxt = PARK;
    endcase
  end

  always_comb begin
    w_clk_nxt   = r_clk;
    w_lead_nxt  = 1'b0;
    w_trail_nxt = 1'b0;
    w_cnt_nxt   = '0;
    w_scnt_nxt  = '0;
    case (r_state)
      PARK:   w_clk_nxt = r_cpol;
      RUN: begin
        if (w_tc) begin
          w_clk_nxt   = ~r_clk;
          w_lead_nxt  = ~w_active;
          w_trail_nxt = w_active;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      LOAD:   w_clk_nxt = r_shd_cpol;
      SETTLE: begin
        w_clk_nxt  = r_cpol;
        w_scnt_nxt = r_scnt + 1'b1;
      end
      default: w_clk_nxt = r_cpol;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_cnt   <= '0;
      r_scnt  <= '0;
      r_clk   <= 1'b0;
      r_lead  <= 1'b0;
      r_trail <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_scnt  <= w_scnt_nxt;
      r_clk   <= w_clk_nxt;
      r_lead  <= w_lead_nxt;
      r_trail <= w_trail_nxt;
      r_busy  <= (w_state_nxt != PARK);
    end
  end

endmodule
